// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: synchronises raw slide-switch levels to the board
// clock and debounces every channel independently for the gate demos.
//
// Ports:
//   I_P_CLK     in   1     board clock, all logic on the rising edge
//   I_P_RST_N   in   1     synchronous active-low reset
//   I_P_SW      in   N_CH  raw asynchronous switch levels
//   O_P_DB      out  N_CH  debounced levels to the gate inputs
//   O_P_LED_SW  out  N_CH  LED mirror of O_P_DB
//   O_P_STABLE  out  1     high when no channel has a pending change
//   O_P_RISE    out  N_CH  one-cycle pulse after a db 0->1 change (*)
//   O_P_FALL    out  N_CH  one-cycle pulse after a db 1->0 change (*)
//   (*) present only when SWITCH_DEBOUNCE_EDGE_PULSE_EN is defined.

module switch_debounce_sync #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            I_P_CLK,
    input  logic            I_P_RST_N,
    input  logic [N_CH-1:0] I_P_SW,
    output logic [N_CH-1:0] O_P_DB,
    output logic [N_CH-1:0] O_P_LED_SW,
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    output logic [N_CH-1:0] O_P_RISE,
    output logic [N_CH-1:0] O_P_FALL,
`endif
    output logic            O_P_STABLE
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A one-cycle qualification window accepts on the first differing
    // cycle, so the pending state is never entered.
    localparam bit SKIP_PEND = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [N_CH-1:0] w_sync;
    logic [N_CH-1:0] w_db;
    logic [N_CH-1:0] w_pend;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_db;
        logic                   w_db_nxt;
        logic                   w_diff;

        // Metastability chain; only the last stage feeds the FSM.
        always_ff @(posedge I_P_CLK) begin
            if (!I_P_RST_N) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], I_P_SW[g]};
            end
        end

        assign w_sync[g] = r_sync[SYNC_STAGES-1];
        assign w_diff    = w_sync[g] ^ r_db;

        always_ff @(posedge I_P_CLK) begin
            if (!I_P_RST_N) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_db    <= w_db_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_db_nxt    = r_db;
            case (r_state)
                ST_IDLE: begin
                    if (w_diff) begin
                        if (SKIP_PEND) begin
                            w_db_nxt = w_sync[g];
                        end else begin
                            w_state_nxt = ST_PEND;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_PEND: begin
                    if (!w_diff) begin
                        // Input fell back before qualifying.
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_db_nxt    = w_sync[g];
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_db[g]   = r_db;
        assign w_pend[g] = (r_state == ST_PEND);

    end

    assign O_P_DB     = w_db;
    assign O_P_LED_SW = w_db;
    assign O_P_STABLE = ~|w_pend;

`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    logic [N_CH-1:0] r_db_prev;
    logic [N_CH-1:0] r_rise;
    logic [N_CH-1:0] r_fall;

    // Reset clears db and its delayed copy together, so a reset that
    // drops db never looks like a falling edge.
    always_ff @(posedge I_P_CLK) begin
        if (!I_P_RST_N) begin
            r_db_prev <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
        end else begin
            r_db_prev <= w_db;
            r_rise    <= w_db & ~r_db_prev;
            r_fall    <= ~w_db & r_db_prev;
        end
    end

    assign O_P_RISE = r_rise;
    assign O_P_FALL = r_fall;
`endif

endmodule
